// File: rtl/rand_port_pkg.sv
// Shared definitions for rand_port: register addresses, STATUS bit positions, reset values.
package rand_port_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    RP_ADDR_DATA   = 2'd0,
    RP_ADDR_LIMIT  = 2'd1,
    RP_ADDR_STATUS = 2'd2,
    RP_ADDR_REJCNT = 2'd3
  } rp_addr_e;

  localparam int RP_ST_NE      = 0;
  localparam int RP_ST_FULL    = 1;
  localparam int RP_ST_CNT_LSB = 2;
  localparam int RP_ST_UFL     = 8;

  localparam logic [DATA_W-1:0] RP_LIMIT_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/rand_port_if.sv
// CPU-side register bus of rand_port; rdata is combinational from addr and slave state.
interface rand_port_if;
  import rand_port_pkg::*;

  logic              cs;
  logic              we;
  logic [1:0]        addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport slave  (input cs, we, addr, wdata, output rdata);
  modport master (output cs, we, addr, wdata, input rdata);

endinterface

// File: rtl/rand_fifo.sv
// DEPTH x DATA_W FIFO, head visible the cycle after push; flush wins over push/pop.
// Push into a full FIFO is taken only together with a pop (slot is recycled).
module rand_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [DATA_W-1:0]          head_dat_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              push_ok;
  logic              pop_ok;

  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign full_o     = (count_o == DEPTH[AW:0]);
  assign empty_o    = (count_o == '0);
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/rand_port.sv
// Mask-and-reject range reduction of a per-cycle generator word into a FIFO, read over a 4-register bus.
// One cycle from rnd_i to FIFO head; when full and not popped, generator words are dropped uncounted.
module rand_port
  import rand_port_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rnd_i,
  rand_port_if.slave        bus_if
);

  localparam int AW = $clog2(DEPTH);

  // Smallest 2^k-1 covering v: smear the leading one rightwards.
  function automatic logic [DATA_W-1:0] smear_mask(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] m;
    m = v;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

  logic [DATA_W-1:0] limit_q, limit_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  rej_q, rej_d;
  logic              ufl_q, ufl_d;

  rp_addr_e          addr_e;
  logic              rd_req, wr_req;
  logic              pop_req, pop, flush, active, accept, push, reject, rej_clr;
  logic [DATA_W-1:0] cand;
  logic [DATA_W-1:0] status;

  logic [DATA_W-1:0] head_dat;
  logic [AW:0]       fifo_cnt;
  logic              fifo_full, fifo_empty;

  assign addr_e = rp_addr_e'(bus_if.addr);
  assign rd_req = bus_if.cs && !bus_if.we;
  assign wr_req = bus_if.cs && bus_if.we;

  always_comb begin
    pop_req = rd_req && (addr_e == RP_ADDR_DATA);
    pop     = pop_req && !fifo_empty;
    flush   = wr_req && (addr_e == RP_ADDR_LIMIT);
    rej_clr = wr_req && ((addr_e == RP_ADDR_STATUS) || (addr_e == RP_ADDR_REJCNT));
    active  = !flush && (!fifo_full || pop);
    cand    = rnd_i & mask_q;
    accept  = (cand <= limit_q);
    push    = active && accept;
    reject  = active && !accept;

    limit_d = limit_q;
    mask_d  = mask_q;
    rej_d   = rej_q;
    ufl_d   = ufl_q;

    if (flush) begin
      limit_d = bus_if.wdata;
      mask_d  = smear_mask(bus_if.wdata);
    end
    if (pop_req && fifo_empty) ufl_d = 1'b1;
    if (wr_req && (addr_e == RP_ADDR_STATUS)) ufl_d = 1'b0;
    // A clear in the same cycle as a rejection leaves the counter at zero.
    if (rej_clr) begin
      rej_d = '0;
    end else if (reject && (rej_q != {CNT_W{1'b1}})) begin
      rej_d = rej_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      limit_q <= RP_LIMIT_RST;
      mask_q  <= RP_LIMIT_RST;
      rej_q   <= '0;
      ufl_q   <= 1'b0;
    end else begin
      limit_q <= limit_d;
      mask_q  <= mask_d;
      rej_q   <= rej_d;
      ufl_q   <= ufl_d;
    end
  end

  rand_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .push_dat_i(cand),
    .pop_i     (pop),
    .flush_i   (flush),
    .head_dat_o(head_dat),
    .count_o   (fifo_cnt),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    status                           = '0;
    status[RP_ST_NE]                 = !fifo_empty;
    status[RP_ST_FULL]               = fifo_full;
    status[RP_ST_CNT_LSB +: AW+1]    = fifo_cnt;
    status[RP_ST_UFL]                = ufl_q;
  end

  always_comb begin
    bus_if.rdata = '0;
    unique case (addr_e)
      RP_ADDR_DATA:   bus_if.rdata = fifo_empty ? '0 : head_dat;
      RP_ADDR_LIMIT:  bus_if.rdata = limit_q;
      RP_ADDR_STATUS: bus_if.rdata = status;
      RP_ADDR_REJCNT: bus_if.rdata = DATA_W'(rej_q);
      default:        bus_if.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_rand_port.sv
// Randomized and directed bench for rand_port against a queue-based reference model.
module tb_rand_port;
  import rand_port_pkg::*;

  localparam int          DEPTH   = 4;
  localparam int          CNT_W   = 4;
  localparam int          REJ_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] SEED    = 32'hCDA9D4AF;
  localparam logic [1:0]  A_DATA  = 2'd0;
  localparam logic [1:0]  A_LIMIT = 2'd1;
  localparam logic [1:0]  A_STAT  = 2'd2;
  localparam logic [1:0]  A_REJ   = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rnd;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  rand_port_if bus();

  rand_port #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rnd_i (rnd),
    .bus_if(bus)
  );

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) rnd <= SEED;
    else        rnd <= xs(rnd);
  end

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  logic [31:0] m_limit, m_mask;
  int          m_rej;
  bit          m_ufl;
  bit          m_ok = 1'b0;

  function automatic logic [31:0] mask_of(input logic [31:0] lim);
    logic [32:0] m;
    m = '0;
    while (m < {1'b0, lim}) m = {m[31:0], 1'b1};
    return m[31:0];
  endfunction

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    logic [31:0] st;
    case (a)
      A_DATA:  return (m_q.size() > 0) ? m_q[0] : 32'h0;
      A_LIMIT: return m_limit;
      A_STAT: begin
        st = 32'(m_q.size()) << 2;
        if (m_q.size() > 0)     st = st | 32'h1;
        if (m_q.size() == DEPTH) st = st | 32'h2;
        if (m_ufl)              st = st | 32'h100;
        return st;
      end
      default: return 32'(m_rej);
    endcase
  endfunction

  always @(posedge clk) begin
    bit pop_req, pop, flush, active;
    logic [31:0] cand;
    if (!rst_n) begin
      m_q.delete();
      m_limit = 32'hFFFF_FFFF;
      m_mask  = 32'hFFFF_FFFF;
      m_rej   = 0;
      m_ufl   = 1'b0;
      m_ok    = 1'b1;
    end else if (m_ok) begin
      pop_req = bus.cs && !bus.we && bus.addr == A_DATA;
      flush   = bus.cs && bus.we && bus.addr == A_LIMIT;
      pop     = pop_req && m_q.size() > 0;
      if (pop_req && m_q.size() == 0) m_ufl = 1'b1;
      if (bus.cs && bus.we && bus.addr == A_STAT) m_ufl = 1'b0;
      active  = !flush && (m_q.size() < DEPTH || pop);
      cand    = rnd & m_mask;
      if (pop) void'(m_q.pop_front());
      if (flush) begin
        m_q.delete();
        m_limit = bus.wdata;
        m_mask  = mask_of(bus.wdata);
      end
      if (active) begin
        if (cand <= m_limit)     m_q.push_back(cand);
        else if (m_rej < REJ_MAX) m_rej++;
      end
      if (bus.cs && bus.we && (bus.addr == A_STAT || bus.addr == A_REJ)) m_rej = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input logic [31:0] act, input logic [31:0] lim);
    checks++;
    if (act > lim) begin
      failures++;
      $display("FAIL %s: got %h expected at most %h", name, act, lim);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok && rst_n && bus.cs && !bus.we)
      check("rdata_vs_model", bus.rdata, model_rdata(bus.addr));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit c, input bit w, input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.cs = c; bus.we = w; bus.addr = a; bus.wdata = d;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, A_STAT, 32'h0);
  endtask

  task automatic rd_get(input logic [1:0] a, output logic [31:0] v);
    drive(1'b1, 1'b0, a, 32'h0);
    @(negedge clk);
    v = bus.rdata;
  endtask

  task automatic rd_lit(input logic [1:0] a, input logic [31:0] exp, input string name);
    logic [31:0] v;
    rd_get(a, v);
    check(name, v, exp);
  endtask

  initial begin
    logic [31:0] v, w;
    logic [31:0] seen[$];
    bit found;
    int r;

    rst_n = 1'b0;
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = A_DATA; bus.wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.cs = 1'b1; bus.addr = A_STAT;
    @(negedge clk);
    check("t1_reset_status", bus.rdata, 32'h0);

    // Test 1: fill with raw generator words
    repeat (3) idle();
    rd_lit(A_STAT, 32'h13, "t1_status_full");
    rd_lit(A_DATA, 32'hCDA9D4AF, "t1_first_word");
    w = xs(SEED);
    for (int i = 0; i < 3; i++) begin
      rd_lit(A_DATA, w, "t1_word_seq");
      w = xs(w);
    end
    rd_lit(A_REJ, 32'h0, "t1_rejcnt");

    // Test 2: LIMIT=5
    drive(1'b1, 1'b1, A_LIMIT, 32'd5);
    idle();
    @(negedge clk);
    check("t2_model_mask", m_mask, 32'h7);
    repeat (19) idle();
    for (int i = 0; i < 8; i++) begin
      rd_get(A_DATA, v);
      check_le("t2_range", v, 32'd5);
      idle();
    end
    rd_lit(A_LIMIT, 32'd5, "t2_limit_rb");
    rd_get(A_REJ, v);

    // Test 3: LIMIT=0
    drive(1'b1, 1'b1, A_REJ, 32'h0);
    drive(1'b1, 1'b1, A_LIMIT, 32'h0);
    idle();
    for (int i = 0; i < 6; i++) rd_lit(A_DATA, 32'h0, "t3_zero");
    rd_lit(A_REJ, 32'h0, "t3_rejcnt");

    // Test 4: read straight after a LIMIT write underflows
    drive(1'b1, 1'b1, A_LIMIT, 32'h100);
    rd_lit(A_DATA, 32'h0, "t4_empty_read");
    check("t4_model_mask", m_mask, 32'h1FF);
    rd_get(A_STAT, v);
    check("t4_ufl_set", v & 32'h100, 32'h100);
    drive(1'b1, 1'b1, A_STAT, 32'h0);
    rd_get(A_STAT, v);
    check("t4_ufl_clr", v & 32'h100, 32'h0);
    rd_lit(A_LIMIT, 32'h100, "t4_limit_rb");
    repeat (4) idle();
    for (int i = 0; i < 8; i++) begin
      rd_get(A_DATA, v);
      check_le("t4_range", v, 32'h100);
    end

    // Test 5: back-to-back reads of a full FIFO
    drive(1'b1, 1'b1, A_LIMIT, 32'h7FFF_FFFF);
    repeat (6) idle();
    rd_lit(A_STAT, 32'h13, "t5_full_before");
    for (int i = 0; i < 10; i++) begin
      rd_get(A_DATA, v);
      foreach (seen[j]) check("t5_distinct", (seen[j] == v) ? 32'h1 : 32'h0, 32'h0);
      seen.push_back(v);
    end
    rd_lit(A_STAT, 32'h13, "t5_full_after");

    // Test 6: saturation, clear-wins, mid-stream reset
    drive(1'b1, 1'b1, A_LIMIT, 32'h8);
    for (int i = 0; i < 120; i++) drive(1'b1, 1'b0, A_DATA, 32'h0);
    rd_lit(A_REJ, 32'hF, "t6_saturated");
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_q.size() < DEPTH && (rnd & m_mask) > m_limit) begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = A_REJ; bus.wdata = 32'h0;
        found = 1'b1;
      end else begin
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = A_DATA; bus.wdata = 32'h0;
      end
    end
    check("t6_scan_found", {31'h0, found}, 32'h1);
    rd_lit(A_REJ, 32'h0, "t6_clear_wins");
    repeat (5) drive(1'b1, 1'b0, A_DATA, 32'h0);

    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = A_LIMIT; bus.wdata = 32'd5;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.we = 1'b0; bus.addr = A_STAT;
    @(negedge clk);
    check("t6_rst_status", bus.rdata, 32'h0);
    rd_lit(A_LIMIT, 32'hFFFF_FFFF, "t6_rst_limit");
    rd_lit(A_REJ, 32'h0, "t6_rst_rejcnt");
    rd_lit(A_DATA, SEED, "t6_rst_first_word");

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      drive(1'b1, 1'b0, A_DATA, $urandom);
      else if (r < 55) drive(1'b1, 1'b0, A_STAT, $urandom);
      else if (r < 65) drive(1'b1, 1'b0, A_REJ, $urandom);
      else if (r < 72) drive(1'b1, 1'b0, A_LIMIT, $urandom);
      else if (r < 76) drive(1'b1, 1'b1, A_LIMIT, ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31)));
      else if (r < 79) drive(1'b1, 1'b1, A_STAT, $urandom);
      else if (r < 82) drive(1'b1, 1'b1, A_REJ, $urandom);
      else if (r < 85) drive(1'b1, 1'b1, A_DATA, $urandom);
      else             drive(1'b0, 1'($urandom), 2'($urandom), $urandom);
    end
    rd_get(A_STAT, v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rand_port.md
Name: rand_port

Overview:
Bus-facing consumer of the 32-bit xorshift generator, which produces a new word every clock. Each cycle it range-reduces the current generator word against a CPU-programmed LIMIT by mask-and-reject sampling. Accepted values go into a small FIFO. The CPU reads them through a 4-register memory-mapped data-bus slave, with status and rejection statistics.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
CNT_W, 16, width of the saturating rejection counter.

Ports:
clk      in   1         clock
rst_n    in   1         reset; synchronous, active-low
rnd_in   in   DATA_W    generator output; new value every cycle
cs       in   1         slave select
we       in   1         write strobe; qualified by cs
addr     in   2         register word address
wdata    in   DATA_W    write data
rdata    out  DATA_W    read data; combinational from addr and current state

Behaviour:
Register map:
- 0 DATA: read returns the FIFO head and pops it at the clock edge. Writes are ignored.
- 1 LIMIT: R/W. A write also flushes the FIFO.
- 2 STATUS: read returns bit0 nonempty, bit1 full, bits[2+log2(DEPTH):2] count, bit8 underflow sticky, other bits 0. Any write clears underflow.
- 3 REJCNT: read returns the rejection count, zero-extended. Any write clears it.

Reset values (synchronous, rst_n=0):
- LIMIT=32'hFFFF_FFFF, MASK=32'hFFFF_FFFF.
- FIFO empty, pointers 0, underflow=0, REJCNT=0.
- rdata follows the reset state, e.g. STATUS reads 0.

Mask and sampling:
- MASK is a register: the smallest 2^k-1 that is >= LIMIT, recomputed and loaded on a LIMIT write. LIMIT=0 gives MASK=0.
- Candidate each cycle: cand = rnd_in & MASK. Accept when cand <= LIMIT.
- Sampling is active in a cycle when the FIFO is not full, or when a DATA pop occurs that same cycle.
- Active and accepted: push cand at the clock edge. Latency is one cycle from rnd_in to visibility at the head, when the FIFO was empty.
- Active and rejected: REJCNT increments, saturating at all ones.
- Inactive (full, no pop): rnd_in is discarded and REJCNT is unchanged.

LIMIT write cycle:
- FIFO is flushed (count=0) and there is no push that cycle.
- LIMIT and MASK update, and REJCNT is unchanged.
- The first candidate under the new mask is sampled the following cycle.

DATA read:
- FIFO empty: rdata=0, no pointer change, underflow is set.
- FIFO full with a push in the same cycle (sampling active via the pop): both happen and count stays DEPTH.
- Nonempty: pop plus push in the same cycle leaves count unchanged.

Count: count = DEPTH is distinguished from 0 by an extra pointer bit or an explicit counter.

Writes: a write of STATUS or REJCNT in the same cycle as a rejection leaves REJCNT at 0. The clear wins.

Reset mid-operation: all state returns to reset values on the next edge, regardless of cs/we. No partial pop.

Side effects: none when cs=0. rdata is still driven, and must not be assumed 0.

Decomposition:
Add to def.h:
- RP_ADDR_DATA/LIMIT/STATUS/REJCNT (2'd0..2'd3)
- STATUS bit positions: RP_ST_NE=0, RP_ST_FULL=1, RP_ST_CNT_LSB=2, RP_ST_UFL=8
- LIMIT reset value

Sub-module rand_fifo is natural: DEPTH x DATA_W synchronous FIFO with push/pop/flush, head, count, full, empty, and simultaneous push+pop when full allowed. The mask function (priority smear of LIMIT) stays local to rand_port.

Test Plan:
1. Reset, generator seeded at 32'hCDA9D4AF, then 4 idle cycles -> STATUS reads count=4, full=1, nonempty=1. The DATA read sequence returns the first 4 generator words: 32'hCDA9D4AF, then successive xorshift(13,17,5) values. REJCNT=0.
2. Write LIMIT=5, wait 20 cycles, then read DATA 8 times, each followed by 1 idle cycle -> every value is <=5 and MASK=7. REJCNT equals the count of sampled words with (rnd & 7) in {6,7}, checked against a reference model.
3. Write LIMIT=0 -> all subsequent DATA reads return 0 and REJCNT stays 0.
4. Write LIMIT=32'h100, then read DATA on the very next cycle -> rdata=0, STATUS bit8=1. Write STATUS -> bit8=0. MASK=32'h1FF, and no value exceeds 32'h100.
5. Full FIFO, then read DATA on 10 consecutive cycles -> each returns a distinct accepted value, count stays 4 throughout, and the stream matches the model.
6. With REJCNT forced near saturation (CNT_W=4 build, LIMIT=0x8 so rejections are frequent) -> REJCNT holds at 4'hF. A write to REJCNT clears it to 0, and the clear wins over a rejection in the same cycle. Asserting rst_n=0 for one cycle mid-stream restores all reset values.
